// File: rtl/lc3b_types.sv
// Shared cache types: 128-bit line, line offset width and the cache controller state encoding.
package lc3b_types;

  localparam int LINE_OFFSET_W = 4;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  // Replace the enabled byte lanes of one 16-bit word inside a line.
  function automatic lc3b_line merge_line(input lc3b_line line, input logic [2:0] word,
                                          input logic [1:0] be, input logic [15:0] wdata);
    lc3b_line merged;
    merged = line;
    if (be[0]) merged[{word, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) merged[{word, 4'b1000} +: 8] = wdata[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/lc3b_dcache_array.sv
// Storage for the direct-mapped data cache: line data and tags (not reset),
// per-set valid/dirty bits cleared asynchronously by rst.
module lc3b_dcache_array
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3,
  parameter int TAG_W    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic [2:0]         word,
  input  logic [1:0]         be,
  input  logic [15:0]        wdata,
  input  logic               word_we,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  lc3b_line           fill_line,
  input  logic               clean,
  output lc3b_line           line_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               valid_out,
  output logic               dirty_out
);

  lc3b_line         data_mem  [NUM_SETS];
  logic [TAG_W-1:0] tag_mem   [NUM_SETS];
  logic             valid_reg [NUM_SETS];
  logic             dirty_reg [NUM_SETS];

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[idx] <= fill_line;
      tag_mem[idx]  <= fill_tag;
    end else if (word_we) begin
      data_mem[idx] <= merge_line(data_mem[idx], word, be, wdata);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          dirty_reg[gi] <= 1'b0;
        end else if (idx == INDEX_W'(gi)) begin
          if (fill_we) begin
            valid_reg[gi] <= 1'b1;
            dirty_reg[gi] <= 1'b0;
          end else if (clean) begin
            dirty_reg[gi] <= 1'b0;
          end else if (word_we) begin
            dirty_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign line_out  = data_mem[idx];
  assign tag_out   = tag_mem[idx];
  assign valid_out = valid_reg[idx];
  assign dirty_out = dirty_reg[idx];

endmodule

// File: rtl/lc3b_dcache.sv
// Direct-mapped write-back/write-allocate data cache with zero-wait hits.
// Define LC3B_DCACHE_PERF_EN to add saturating hit/miss/writeback counters.
module lc3b_dcache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output lc3b_line     pmem_wdata,
  input  lc3b_line     pmem_rdata,
  input  logic         pmem_resp
`ifdef LC3B_DCACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count,
  output logic [15:0]  wb_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 16 - INDEX_W - LINE_OFFSET_W;

  cache_state_t state_reg, state_next;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag, tag_out;
  logic [2:0]         word;
  lc3b_line           line_out;
  logic               valid_out, dirty_out, hit, req;
  logic               word_we, fill_we, clean;
  logic               unused_addr_bit;

  assign idx             = mem_address[LINE_OFFSET_W +: INDEX_W];
  assign addr_tag        = mem_address[15 -: TAG_W];
  assign word            = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign req             = mem_read | mem_write;
  assign hit             = valid_out && (tag_out == addr_tag);

  lc3b_dcache_array #(
    .NUM_SETS (NUM_SETS),
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .word      (word),
    .be        (mem_byte_enable),
    .wdata     (mem_wdata),
    .word_we   (word_we),
    .fill_we   (fill_we),
    .fill_tag  (addr_tag),
    .fill_line (pmem_rdata),
    .clean     (clean),
    .line_out  (line_out),
    .tag_out   (tag_out),
    .valid_out (valid_out),
    .dirty_out (dirty_out)
  );

  // Read data is the pre-write word even when a write hits in the same cycle.
  assign mem_rdata  = line_out[{word, 4'b0000} +: 16];
  assign pmem_wdata = line_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    word_we      = 1'b0;
    fill_we      = 1'b0;
    clean        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            word_we  = mem_write && (mem_byte_enable != 2'b00);
          end else if (valid_out && dirty_out) begin
            state_next = WRITEBACK;
          end else begin
            state_next = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, idx, 4'b0000};
        if (pmem_resp) begin
          clean      = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, idx, 4'b0000};
        if (pmem_resp) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef LC3B_DCACHE_PERF_EN
  // The response right after a fill is the tail of a miss, not a hit.
  logic filled_reg;
  logic count_hit, count_miss, count_wb;

  assign count_hit  = (state_reg == IDLE) && req && hit && !filled_reg;
  assign count_miss = (state_reg == IDLE) && (state_next != IDLE);
  assign count_wb   = clean;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled_reg <= 1'b0;
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
      wb_count   <= 16'h0000;
    end else begin
      filled_reg <= fill_we;
      if (count_hit  && hit_count  != 16'hFFFF) hit_count  <= hit_count + 16'h0001;
      if (count_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'h0001;
      if (count_wb   && wb_count   != 16'hFFFF) wb_count   <= wb_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_dcache.sv
// Self-checking bench for lc3b_dcache: flat-memory reference model plus a
// residency model of which line each set holds, against a random-latency memory.
module tb_lc3b_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  lc3b_dcache #(.NUM_SETS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  int tests = 0;
  int fails = 0;

  logic [127:0] pmem_mem [4096];   // physical memory, one entry per line
  logic [15:0]  ref_mem  [32768];  // CPU-visible word memory
  logic [8:0]   mtag     [8];
  bit           mvalid   [8];
  bit           mdirty   [8];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resync_ref();
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        ref_mem[l*8 + w] = pmem_mem[l][w*16 +: 16];
  endtask

  // Physical memory: responds 1..4 cycles after a request appears, one-cycle pmem_resp.
  initial begin
    int lat, tgt;
    lat = 0;
    tgt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || pmem_resp) begin
        pmem_resp = 1'b0;
        lat = 0;
        tgt = int'($urandom_range(0, 3));
      end else if (pmem_read || pmem_write) begin
        if (lat >= tgt) begin
          if (pmem_write) pmem_mem[pmem_address[15:4]] = pmem_wdata;
          else            pmem_rdata = pmem_mem[pmem_address[15:4]];
          pmem_resp = 1'b1;
        end else begin
          lat++;
        end
      end
    end
  end

  // One CPU transaction, started at a negedge; returns at the negedge after the response.
  task automatic access(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd, output logic [15:0] rdata);
    logic [2:0]   set;
    logic [8:0]   tg;
    logic [14:0]  widx;
    logic [15:0]  victim, exp_word;
    logic [127:0] exp_line;
    bit           exp_hit, exp_wb, saw_wb, saw_fill, prev_rd, got;
    int           cycles;
    set      = addr[6:4];
    tg       = addr[15:7];
    widx     = addr[15:1];
    exp_hit  = mvalid[set] && (mtag[set] == tg);
    exp_wb   = !exp_hit && mvalid[set] && mdirty[set];
    victim   = {mtag[set], set, 4'b0000};
    for (int w = 0; w < 8; w++) exp_line[w*16 +: 16] = ref_mem[int'(victim[15:4])*8 + w];
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    saw_wb = 0; saw_fill = 0; prev_rd = 0; got = 0; cycles = 0;
    rdata = 16'h0000;
    while (!got && cycles < 200) begin
      #1;
      chk("pmem_excl", 128'(pmem_read & pmem_write), 128'(0));
      if (pmem_write && !saw_wb) begin
        saw_wb = 1;
        chk("wb_addr", 128'(pmem_address), 128'(victim));
        chk("wb_data", pmem_wdata, exp_line);
      end
      if (pmem_read && !saw_fill) begin
        saw_fill = 1;
        chk("fill_addr", 128'(pmem_address), 128'({addr[15:4], 4'b0000}));
      end
      if (prev_rd && !pmem_read) chk("resp_after_fill", 128'(mem_resp), 128'(1));
      prev_rd = pmem_read;
      if (mem_resp) begin
        got      = 1;
        rdata    = mem_rdata;
        exp_word = ref_mem[widx];
        chk("rdata", 128'(mem_rdata), 128'(exp_word));
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!got) chk("resp_timeout", 128'(0), 128'(1));
    chk("miss_seen", 128'(saw_fill), 128'(!exp_hit));
    chk("wb_seen", 128'(saw_wb), 128'(exp_wb));
    if (exp_hit) chk("hit_zero_wait", 128'(cycles), 128'(0));
    if (!exp_hit) begin
      mvalid[set] = 1;
      mtag[set]   = tg;
      mdirty[set] = 0;
    end
    if (wr && be != 2'b00) begin
      if (be[0]) ref_mem[widx][7:0]  = wd[7:0];
      if (be[1]) ref_mem[widx][15:8] = wd[15:8];
      mdirty[set] = 1;
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [15:0] r, a, wd;
    logic [1:0]  be;
    int          op;
    bit          seen;
    rst = 1'b1;
    mem_address = '0; mem_read = 0; mem_write = 0; mem_byte_enable = '0; mem_wdata = '0;
    for (int l = 0; l < 4096; l++) pmem_mem[l] = {$urandom, $urandom, $urandom, $urandom};
    pmem_mem[4][31:16] = 16'hBEEF;
    resync_ref();
    for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; mtag[s] = '0; end

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    access(16'h0042, 1, 0, 2'b00, 16'h0000, r);
    chk("first_fill", 128'(r), 128'(16'hBEEF));
    access(16'h0042, 1, 0, 2'b00, 16'h0000, r);
    chk("reread_hit", 128'(r), 128'(16'hBEEF));
    access(16'h0042, 0, 1, 2'b01, 16'h12AB, r);
    access(16'h0042, 1, 0, 2'b00, 16'h0000, r);
    chk("byte_merge", 128'(r), 128'(16'hBEAB));
    access(16'h00C2, 1, 0, 2'b00, 16'h0000, r);
    chk("wb_mem_word", 128'(pmem_mem[4][31:16]), 128'(16'hBEAB));
    access(16'h00C2, 0, 1, 2'b00, 16'hFFFF, r);
    access(16'h0142, 1, 0, 2'b00, 16'h0000, r);
    chk("be00_clean", 128'(pmem_mem[12]), 128'({ref_mem[103], ref_mem[102], ref_mem[101],
        ref_mem[100], ref_mem[99], ref_mem[98], ref_mem[97], ref_mem[96]}));

    for (int i = 0; i < 300; i++) begin
      a  = 16'($urandom_range(0, 1023));
      op = int'($urandom_range(0, 3));
      be = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      access(a, op != 2, op >= 2, be, wd, r);
    end

    // Reset in the middle of a line fill.
    mem_address = 16'h7000; mem_read = 1; mem_write = 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (pmem_read) seen = 1;
    end
    chk("alloc_reached", 128'(seen), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_drop_read", 128'(pmem_read), 128'(0));
    chk("rst_drop_write", 128'(pmem_write), 128'(0));
    chk("rst_drop_resp", 128'(mem_resp), 128'(0));
    chk("rst_drop_addr", 128'(pmem_address), 128'(0));
    mem_read = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; end
    resync_ref();
    @(negedge clk);
    access(16'h7000, 1, 0, 2'b00, 16'h0000, r);
    access(16'h0042, 1, 0, 2'b00, 16'h0000, r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
